// File: rtl/sqrt_fp_iter_if.sv
// Operand/result handshake bundle for the iterative floating-point square root.
// The slave side is the sqrt unit; the master side is whoever feeds operands
// and consumes results.
interface sqrt_fp_iter_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         is_nan;
    logic         is_pinf;
    logic         is_inval;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, is_nan, is_pinf, is_inval, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, is_nan, is_pinf, is_inval, busy
    );
endinterface

// File: rtl/sqrt_fp_iter.sv
// Iterative IEEE-754 square root, one root bit per cycle (restoring recurrence),
// round-to-nearest-even, with optional subnormal normalisation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an operand, in_ready high
// PREP   | classify operand, normalise significand, halve exponent
// ITER   | MAN_W+2 recurrence steps (integer bit, MAN_W fraction, guard)
// ROUND  | RNE on guard/sticky/lsb; special results simply pass through
// DONE   | result presented until the consumer takes it
module sqrt_fp_iter #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int SUBNORM = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    sqrt_fp_iter_if.slave  fp_io
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int ROOT_W = MAN_W + 2;
    localparam int REM_W  = MAN_W + 4;
    localparam int RAD_W  = 2 * ROOT_W;
    localparam int XW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(MAN_W + 2) + 1;
    localparam int LZ_W   = $clog2(MAN_W) + 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       op_q, op_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [ROOT_W-1:0]  root_q, root_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]      exp_q, exp_d;
    logic [W-1:0]       res_q, res_d;
    logic               nan_q, nan_d;
    logic               pinf_q, pinf_d;
    logic               inval_q, inval_d;
    logic               special_q, special_d;

    // operand fields
    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [MAN_W-1:0]   op_man;
    logic               exp_zero;
    logic               exp_ones;
    logic               man_zero;

    assign op_sign  = op_q[W-1];
    assign op_exp   = op_q[W-2:MAN_W];
    assign op_man   = op_q[MAN_W-1:0];
    assign exp_zero = (op_exp == '0);
    assign exp_ones = &op_exp;
    assign man_zero = (op_man == '0);

    // leading-zero count of the stored mantissa (highest set bit wins)
    logic [LZ_W-1:0] lz;
    always_comb begin
        lz = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (op_man[i]) begin
                lz = LZ_W'(MAN_W - 1 - i);
            end
        end
    end

    // normalise significand, make the unbiased exponent even, halve it
    logic [MAN_W:0]    sig_sub;
    logic [MAN_W:0]    sig_pre;
    logic [ROOT_W-1:0] sig2;
    logic [XW-1:0]     exp_unb;
    logic [XW-1:0]     exp_even;
    logic [XW-1:0]     exp_res;
    always_comb begin
        sig_sub = {1'b0, op_man} << (lz + LZ_W'(1));
        if (exp_zero) begin
            // subnormal: value = m * 2^(1-bias-MAN_W); leading 1 moved to bit MAN_W
            sig_pre = sig_sub;
            exp_unb = XW'(0) - XW'(BIAS) - XW'(lz);
        end else begin
            sig_pre = {1'b1, op_man};
            exp_unb = {2'b00, op_exp} - XW'(BIAS);
        end
        // odd exponent: radicand doubled into [2,4) so the exponent halves exactly
        if (exp_unb[0]) begin
            sig2 = {sig_pre, 1'b0};
        end else begin
            sig2 = {1'b0, sig_pre};
        end
        exp_even = exp_unb - XW'(exp_unb[0]);
        exp_res  = {exp_even[XW-1], exp_even[XW-1:1]} + XW'(BIAS);
    end

    // one restoring step: bring down two radicand bits, try (4q+1)
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    logic [REM_W:0]   diff;
    always_comb begin
        rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        diff   = {1'b0, rem_sh} - {1'b0, trial};
    end

    // round to nearest even; a carry out renormalises to man=0, exp+1
    logic           rnd_up;
    logic [MAN_W:0] man_sum;
    logic [XW-1:0]  exp_rnd;
    logic [W-1:0]   res_rnd;
    always_comb begin
        rnd_up  = root_q[0] & ((|rem_q) | root_q[1]);
        man_sum = {1'b0, root_q[MAN_W:1]} + {{MAN_W{1'b0}}, rnd_up};
        exp_rnd = exp_q + XW'(man_sum[MAN_W]);
        res_rnd = {1'b0, exp_rnd[EXP_W-1:0], man_sum[MAN_W-1:0]};
    end

    logic unused_bits;
    assign unused_bits = ^{exp_even[0], exp_rnd[XW-1:EXP_W], root_q[ROOT_W-1]};

    // next-state and datapath control
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        res_d     = res_q;
        nan_d     = nan_q;
        pinf_d    = pinf_q;
        inval_d   = inval_q;
        special_d = special_q;

        unique case (state_q)
            S_IDLE: begin
                if (fp_io.in_valid) begin
                    op_d    = fp_io.in_data;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                nan_d     = 1'b0;
                pinf_d    = 1'b0;
                inval_d   = 1'b0;
                special_d = 1'b1;
                // specials skip ITER but still spend one cycle in ROUND
                state_d   = S_ROUND;
                if (exp_ones && !man_zero) begin
                    res_d   = QNAN;
                    nan_d   = 1'b1;
                    inval_d = ~op_man[MAN_W-1];
                end else if (exp_ones) begin
                    if (op_sign) begin
                        res_d   = QNAN;
                        nan_d   = 1'b1;
                        inval_d = 1'b1;
                    end else begin
                        res_d  = PINF;
                        pinf_d = 1'b1;
                    end
                end else if (exp_zero && (man_zero || SUBNORM == 0)) begin
                    res_d = {op_sign, {(W-1){1'b0}}};
                end else if (op_sign) begin
                    res_d   = QNAN;
                    nan_d   = 1'b1;
                    inval_d = 1'b1;
                end else begin
                    special_d = 1'b0;
                    rad_d     = {sig2, {ROOT_W{1'b0}}};
                    rem_d     = '0;
                    root_d    = '0;
                    cnt_d     = CNT_W'(MAN_W + 1);
                    exp_d     = exp_res;
                    state_d   = S_ITER;
                end
            end

            S_ITER: begin
                rad_d = {rad_q[RAD_W-3:0], 2'b00};
                if (!diff[REM_W]) begin
                    rem_d = diff[REM_W-1:0];
                end else begin
                    rem_d = rem_sh;
                end
                root_d = {root_q[ROOT_W-2:0], ~diff[REM_W]};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                if (!special_q) begin
                    res_d = res_rnd;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (fp_io.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            res_q     <= '0;
            nan_q     <= 1'b0;
            pinf_q    <= 1'b0;
            inval_q   <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
            nan_q     <= nan_d;
            pinf_q    <= pinf_d;
            inval_q   <= inval_d;
            special_q <= special_d;
        end
    end

    logic done;
    assign done = (state_q == S_DONE);

    assign fp_io.in_ready  = (state_q == S_IDLE);
    assign fp_io.out_valid = done;
    assign fp_io.out_data  = done ? res_q : '0;
    assign fp_io.is_nan    = done & nan_q;
    assign fp_io.is_pinf   = done & pinf_q;
    assign fp_io.is_inval  = done & inval_q;
    assign fp_io.busy      = (state_q != S_IDLE);

endmodule
